// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice plus a carry flop,
// LSB-first, with valid/ready handshakes on operands and result.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [NW-1:0]    n_q, n_d;
  logic             c_q, c_d;
  logic             cin_msb_q, cin_msb_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  logic             bit_s;
  logic             bit_cy;

  // The single full-adder slice shared by every bit position.
  assign bit_s  = sa_q[0] ^ sb_q[0] ^ c_q;
  assign bit_cy = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);

  always_comb begin
    state_d     = state_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    sum_d       = sum_q;
    n_d         = n_q;
    c_d         = c_q;
    cin_msb_d   = cin_msb_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          c_d     = sub;
          n_d     = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d = {bit_s, sum_q[WIDTH-1:1]};
        c_d   = bit_cy;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        n_d   = n_q + 1'b1;
        if (n_q == NW'(WIDTH - 2)) begin
          cin_msb_d = bit_cy;
        end
        if (n_q == NW'(WIDTH - 1)) begin
          // Signed overflow: carry into the MSB differs from carry out of it.
          carry_out_d = bit_cy;
          overflow_d  = cin_msb_q ^ bit_cy;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sa_q        <= '0;
      sb_q        <= '0;
      sum_q       <= '0;
      n_q         <= '0;
      c_q         <= 1'b0;
      cin_msb_q   <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      sum_q       <= sum_d;
      n_q         <= n_d;
      c_q         <= c_d;
      cin_msb_q   <= cin_msb_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: a scoreboard queue of expected results
// filled on accept and drained when the result handshake is presented.
module tb_serial_add_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Reference: full-width integer arithmetic and the sign rule for overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
    logic [W:0] full;
    exp_t e;
    if (op) full = {1'b0, x} + {1'b0, ~y} + 1;
    else    full = {1'b0, x} + {1'b0, y};
    e.s  = full[W-1:0];
    e.co = full[W];
    if (op) e.ov = (x[W-1] != y[W-1]) && (e.s[W-1] != x[W-1]);
    else    e.ov = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    return e;
  endfunction

  // Called #1 after an edge; operands are accepted on the next rising edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic op, input bit track);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    a = x; b = y; sub = op; in_valid = 1'b1;
    if (track) exp_q.push_back(model(x, y, op));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op, input int bp);
    exp_t e;
    out_ready = (bp == 0);
    send(x, y, op, 1'b1);
    check("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (i == W - 1) check("out_valid_early", {31'd0, out_valid}, 32'd0);
    end
    check("out_valid_latency", {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("sum", {24'd0, sum}, {24'd0, e.s});
    check("carry_out", {31'd0, carry_out}, {31'd0, e.co});
    check("overflow", {31'd0, overflow}, {31'd0, e.ov});
    $display("op a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h co=%0d ov=%0d (exp 0x%02h %0d %0d)",
             x, y, op, sum, carry_out, overflow, e.s, e.co, e.ov);
    for (int i = 0; i < bp; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_sum_stable", {24'd0, sum}, {24'd0, e.s});
      check("bp_carry_stable", {31'd0, carry_out}, {31'd0, e.co});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("handshake_out_valid", {31'd0, out_valid}, 32'd0);
    check("handshake_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry_out}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd3, 8'd5, 1'b0, 0);
    run_op(8'd200, 8'd100, 1'b0, 0);
    run_op(8'd100, 8'd100, 1'b0, 0);
    run_op(8'd5, 8'd7, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b1, 0);
    run_op(8'h7F, 8'h80, 1'b1, 5);
    // Follows the backpressured handshake by one cycle.
    run_op(8'hFF, 8'hFF, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), i % 3);

    // Abort an operation three bits into RUN.
    out_ready = 1'b1;
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_sum", {24'd0, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      check("no_stale_result", {31'd0, out_valid}, 32'd0);
    end
    run_op(8'd3, 8'd5, 1'b0, 0);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
